// File: rtl/rect_swap_sched.sv
// rect_swap_sched: rectangle-loop (checkerboard swap) scheduler over a
// MATRIX_ROW x MATRIX_COL bit matrix. Random 2x2 submatrices are picked
// from a 16-bit LFSR and flipped when they form a checkerboard, which
// keeps every row and column sum intact.
// Optional feature macro: RECT_SWAP_STATS_EN builds the saturating swap
// counter; without it swap_cnt is tied to zero.
module rect_swap_sched #(
    parameter int          MATRIX_ROW = 8,
    parameter int          MATRIX_COL = 8,
    parameter int          ITERATION  = 256,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  wr_en,
    input  logic [3:0]            wr_row,
    input  logic [MATRIX_COL-1:0] wr_data,
    input  logic [3:0]            rd_row,
    output logic [MATRIX_COL-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           swap_cnt
);

    localparam int                  IW       = $clog2(ITERATION + 1);
    localparam logic [IW-1:0]       LAST     = IW'(ITERATION - 1);
    localparam logic [15:0]         SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [4:0]          NROW     = 5'(MATRIX_ROW);
    localparam logic [4:0]          NCOL     = 5'(MATRIX_COL);
    localparam logic [MATRIX_COL-1:0] ONE    = MATRIX_COL'(1);

    typedef enum logic [2:0] {IDLE, PICK, CHECK, SWAP, DONE} state_t;

    state_t                             state_q, state_d;
    logic [15:0]                        lfsr_q, lfsr_d;
    logic [3:0]                         r0_q, c0_q, r1_q, c1_q;
    logic [3:0]                         r0_d, c0_d, r1_d, c1_d;
    logic [IW-1:0]                      iter_q, iter_d;
    logic [MATRIX_ROW-1:0][MATRIX_COL-1:0] mat_q;

    logic [3:0]            p_r0, p_c0, p_r1, p_c1;
    logic                  pick_ok;
    logic [15:0]           lfsr_nxt;
    logic [MATRIX_COL-1:0] row_a, row_b;
    logic [MATRIX_COL-1:0] a0, a1, b0, b1;
    logic [3:0]            sub;
    logic                  is_chk;
    logic                  last_iter;
    logic                  do_wr, do_swap;
    logic [MATRIX_COL-1:0] swap_mask;

    // Candidate indices come straight from the current LFSR word.
    assign p_r0     = lfsr_q[3:0];
    assign p_c0     = lfsr_q[7:4];
    assign p_r1     = lfsr_q[11:8];
    assign p_c1     = lfsr_q[15:12];
    assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign pick_ok  = (p_r0 != p_r1) && (p_c0 != p_c1) &&
                      ({1'b0, p_r0} < NROW) && ({1'b0, p_r1} < NROW) &&
                      ({1'b0, p_c0} < NCOL) && ({1'b0, p_c1} < NCOL);

    // Row muxes for the read port and the two latched rows under test.
    always_comb begin
        row_a   = '0;
        row_b   = '0;
        rd_data = '0;
        for (int i = 0; i < MATRIX_ROW; i++) begin
            if (r0_q == 4'(i))   row_a   = mat_q[i];
            if (r1_q == 4'(i))   row_b   = mat_q[i];
            if (rd_row == 4'(i)) rd_data = mat_q[i];
        end
    end

    assign a0        = row_a >> c0_q;
    assign a1        = row_a >> c1_q;
    assign b0        = row_b >> c0_q;
    assign b1        = row_b >> c1_q;
    assign sub       = {a0[0], a1[0], b0[0], b1[0]};
    assign is_chk    = (sub == 4'b1001) || (sub == 4'b0110);
    assign last_iter = (iter_q == LAST);
    assign swap_mask = (ONE << c0_q) | (ONE << c1_q);
    assign do_wr     = (state_q == IDLE) && wr_en && ({1'b0, wr_row} < NROW);
    assign do_swap   = (state_q == SWAP);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    // Next-state logic: pick sequencing, iteration counting, termination.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        r0_d    = r0_q;
        c0_d    = c0_q;
        r1_d    = r1_q;
        c1_d    = c1_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PICK;
                    iter_d  = '0;
                end
            end
            PICK: begin
                lfsr_d = lfsr_nxt;
                if (pick_ok) begin
                    r0_d    = p_r0;
                    c0_d    = p_c0;
                    r1_d    = p_r1;
                    c1_d    = p_c1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (is_chk) begin
                    state_d = SWAP;
                end else begin
                    iter_d  = iter_q + 1'b1;
                    state_d = last_iter ? DONE : PICK;
                end
            end
            SWAP: begin
                iter_d  = iter_q + 1'b1;
                state_d = last_iter ? DONE : PICK;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_EFF;
            r0_q    <= '0;
            c0_q    <= '0;
            r1_q    <= '0;
            c1_q    <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            r0_q    <= r0_d;
            c0_q    <= c0_d;
            r1_q    <= r1_d;
            c1_q    <= c1_d;
            iter_q  <= iter_d;
        end
    end

    // Matrix storage: host row writes in IDLE, four-cell flip in SWAP.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MATRIX_ROW; i++) begin
            if (rst) begin
                mat_q[i] <= '0;
            end else if (do_wr && (wr_row == 4'(i))) begin
                mat_q[i] <= wr_data;
            end else if (do_swap && ((r0_q == 4'(i)) || (r1_q == 4'(i)))) begin
                mat_q[i] <= mat_q[i] ^ swap_mask;
            end
        end
    end

`ifdef RECT_SWAP_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating swap counter, cleared when a run is accepted.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == IDLE) && start)            cnt_d = '0;
        else if (do_swap && (cnt_q != 16'hFFFF))   cnt_d = cnt_q + 16'd1;
    end

    // Swap counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign swap_cnt = cnt_q;
`else
    assign swap_cnt = 16'h0000;
`endif

endmodule

// File: doc/rect_swap_sched.md
# rect_swap_sched

Sequential scheduler for the rectangle-loop (checkerboard swap) move on a binary matrix. It owns a `MATRIX_ROW` x `MATRIX_COL` bit matrix and draws random row and column index pairs from an internal LFSR. When the 2x2 submatrix at those indices is a checkerboard unit, it flips all four cells. It runs `ITERATION` attempts per start, which preserves every row and column sum, and is the block that sequences the rectangle-loop datapath during a randomization run.

## Interface
- `MATRIX_ROW`, 8: number of rows, legal range 2..16.
- `MATRIX_COL`, 8: number of columns, legal range 2..16.
- `ITERATION`, 256: counted attempts per run, must be at least 1.
- `SEED`, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle run request, honoured only in IDLE.
- `wr_en`  in  1  row load strobe, honoured only in IDLE.
- `wr_row`  in  4  row index to load.
- `wr_data`  in  MATRIX_COL  row contents; bit j is column j.
- `rd_row`  in  4  row index to read.
- `rd_data`  out  MATRIX_COL  combinational read of row `rd_row`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `swap_cnt`  out  16  swaps performed in the current or last run, saturating.

## Operation
- State machine states: IDLE, PICK, CHECK, SWAP, DONE.
- IDLE:
  - `start` moves to PICK and clears `iter_cnt` and `swap_cnt`.
  - `wr_en` with `wr_row` < `MATRIX_ROW` writes the row; an out-of-range `wr_row` is ignored.
  - If `start` and `wr_en` arrive together, the write happens first and then the run starts.
- PICK:
  - Indices are taken from the current LFSR value: r0=lfsr[3:0], c0=lfsr[7:4], r1=lfsr[11:8], c1=lfsr[15:12].
  - The LFSR advances on every PICK cycle: next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - A pick is rejected when r0==r1, c0==c1, any r is >= `MATRIX_ROW`, or any c is >= `MATRIX_COL`. A rejected pick stays in PICK and does not count as an iteration.
  - A valid pick latches the indices and moves to CHECK.
- CHECK:
  - Forms sub = {m[r0][c0], m[r0][c1], m[r1][c0], m[r1][c1]}.
  - sub == 4'b1001 or 4'b0110 moves to SWAP.
  - Any other value counts one iteration and moves to DONE if `iter_cnt`==`ITERATION`-1, otherwise to PICK.
- SWAP:
  - Inverts the four latched cells in one cycle.
  - Increments `swap_cnt`, saturating at 16'hFFFF.
  - Counts one iteration, with the same termination rule as CHECK.
- DONE: asserts `done` for one cycle, then returns to IDLE.
- `rd_data` is always live. During a run it reflects the matrix as it is being modified.
- `start` while busy is ignored. `wr_en` while busy is ignored; the matrix is not written.
- `rd_row` >= `MATRIX_ROW` returns all zeros.
- Invariant: the row sums and column sums after a run equal those before it.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `swap_cnt`=0, lfsr=`SEED`, matrix all 0, `iter_cnt`=0.
- Reset is synchronous and overrides everything. Reset in any state returns to IDLE on the next edge and clears the matrix.
- `start` is sampled at edge N. `busy` rises at N+1 (PICK).
- Each counted iteration costs PICK(s) + CHECK, plus SWAP when a swap is taken: 2 cycles minimum, 3 with a swap, plus 1 cycle per rejected pick.
- `done` is high the cycle after the last CHECK or SWAP. `busy` is low the following cycle.
- A row write takes effect at the edge where `wr_en` is sampled. `rd_data` shows the new row the next cycle.
- `iter_cnt` width is $clog2(`ITERATION`+1).

## Configuration
- `RECT_SWAP_STATS_EN` defined: `swap_cnt` counts as specified above.
- `RECT_SWAP_STATS_EN` undefined: the counter is not built and `swap_cnt` is tied to 16'h0000. All other behaviour is identical.

## Test plan
- Reset check: assert `rst` for 2 cycles -> `busy`=0, `done`=0, `swap_cnt`=0, and `rd_data`=0 for every row.
- 2x2, ITERATION=1: load {{1,0},{0,1}}, pulse `start` -> every valid pick is a swap, so the result is {{0,1},{1,0}}, `swap_cnt`=1, and `done` arrives exactly 1 cycle after SWAP.
- 4x4 all-zero, ITERATION=16: run -> matrix unchanged, `swap_cnt`=0, exactly 16 CHECK cycles.
- 8x8 random, ITERATION=256, `SEED`=16'hACE1: run -> all row and column sums preserved; matrix and `swap_cnt` match the reference model cycle-exactly.
- Busy protection: during a run, pulse `wr_en` (row 0 = 8'hFF) and pulse `start` -> neither is honoured, and the run ends after exactly `ITERATION` counted iterations.
- Reset mid-run: assert `rst` while in SWAP -> IDLE next cycle, matrix zero, lfsr=`SEED`; a subsequent identical load and run reproduces the first run's result.
